// File: rtl/div_pipe.sv
// div_pipe: fully pipelined restoring divider, M-bit dividend by N-bit divisor.
// Latency M+2 cycles, one operand pair accepted per cycle.
// Valid-only flow: there is no backpressure, so every accepted sample emerges.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   div_in_valid/a/b                operand pair (dividend M bits, divisor N bits)
//   div_out_valid/quot/rem/zero     result, with a flag set when the divisor was zero
//
// Configuration macro: DIV_PIPE_UNSIGNED_EN
//   defined   -> operands and results are unsigned
//   undefined -> two's complement (quotient truncates toward zero, remainder
//                takes the sign of the dividend)
//
// Pipeline layout:
//   stage 0      operand magnitudes, signs and the divide-by-zero flag
//   stages 1..M  one quotient bit per stage, MSB first
//   output       sign correction and the output registers
module div_pipe #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_in_valid,
  input  logic [M-1:0] div_in_a,
  input  logic [N-1:0] div_in_b,
  output logic         div_out_valid,
  output logic [M-1:0] div_out_quot,
  output logic [N-1:0] div_out_rem,
  output logic         div_out_zero
);

  // Per-stage valid bits; vld[k] qualifies the data held in stage k.
  logic [M:0] vld;

  // Per-stage data.
  // dq holds the dividend bits still to be consumed in its upper part and the
  // quotient bits already resolved in its lower part. Each stage shifts one
  // dividend bit out of the top and one quotient bit in at the bottom.
  logic [N-1:0] pr_q [0:M];  // partial remainder, always < |b|
  logic [M-1:0] dq_q [0:M];  // dividend / quotient shift register
  logic [N-1:0] b_q  [0:M];  // divisor magnitude
  logic [M:0]   bz_q;        // divisor was zero
`ifndef DIV_PIPE_UNSIGNED_EN
  logic [M:0]   sa_q;        // sign of the dividend
  logic [M:0]   sb_q;        // sign of the divisor
`endif

  // Stage 0 operand conditioning.
  logic [M-1:0] abs_a;
  logic [N-1:0] abs_b;
`ifndef DIV_PIPE_UNSIGNED_EN
  logic         sign_a;
  logic         sign_b;
`endif

  always_comb begin
`ifdef DIV_PIPE_UNSIGNED_EN
    abs_a = div_in_a;
    abs_b = div_in_b;
`else
    sign_a = div_in_a[M-1];
    sign_b = div_in_b[N-1];
    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly the wanted magnitude 2^(width-1).
    abs_a  = sign_a ? (~div_in_a + 1'b1) : div_in_a;
    abs_b  = sign_b ? (~div_in_b + 1'b1) : div_in_b;
`endif
  end

  // One restoring step.
  // The shifted remainder needs N+1 bits, because the partial remainder can be
  // as large as |b|-1 <= 2^N - 2 before the shift. After an optional
  // subtraction the result is < |b|, so it fits back into N bits. That is why
  // a modular N-bit subtract is exact here.
  function automatic logic [N+M-1:0] div_step(
    input logic [N-1:0] pr,
    input logic [M-1:0] dq,
    input logic [N-1:0] b
  );
    logic [N:0]   sh;
    logic [N-1:0] diff;
    logic         ge;
    sh   = {pr, dq[M-1]};
    ge   = (sh >= {1'b0, b});
    diff = sh[N-1:0] - b;
    return {(ge ? diff : sh[N-1:0]), dq[M-2:0], ge};
  endfunction

  // Valid chain and output registers: reset clears everything that is visible.
  // While rst is high no new valid enters, so a simultaneous input is dropped.
  logic [M-1:0] quot_mag;
  logic [N-1:0] rem_mag;
  logic [M-1:0] quot_fin;
  logic [N-1:0] rem_fin;

  always_comb begin
    quot_mag = dq_q[M];
    rem_mag  = pr_q[M];
`ifdef DIV_PIPE_UNSIGNED_EN
    quot_fin = quot_mag;
    rem_fin  = rem_mag;
`else
    // -2^(M-1) / -1 gives magnitude 2^(M-1) with no negation. This wraps
    // naturally to -2^(M-1) in M bits.
    quot_fin = (sa_q[M] ^ sb_q[M]) ? (~quot_mag + 1'b1) : quot_mag;
    rem_fin  = sa_q[M] ? (~rem_mag + 1'b1) : rem_mag;
`endif
    // Divide by zero has a fixed result pattern regardless of the datapath.
    if (bz_q[M]) begin
      quot_fin = '1;
      rem_fin  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld           <= '0;
      div_out_valid <= 1'b0;
      div_out_quot  <= '0;
      div_out_rem   <= '0;
      div_out_zero  <= 1'b0;
    end else begin
      vld           <= {vld[M-1:0], div_in_valid};
      div_out_valid <= vld[M];
      if (vld[M]) begin
        div_out_quot <= quot_fin;
        div_out_rem  <= rem_fin;
        div_out_zero <= bz_q[M];
      end
    end
  end

  // Datapath registers.
  // These are not reset. They load only behind a valid, and any stale
  // contents are never qualified by a valid bit.
  always_ff @(posedge clk) begin
    if (div_in_valid) begin
      pr_q[0] <= '0;
      dq_q[0] <= abs_a;
      b_q[0]  <= abs_b;
      bz_q[0] <= (div_in_b == '0);
`ifndef DIV_PIPE_UNSIGNED_EN
      sa_q[0] <= sign_a;
      sb_q[0] <= sign_b;
`endif
    end
    for (int k = 1; k <= M; k++) begin
      if (vld[k-1]) begin
        {pr_q[k], dq_q[k]} <= div_step(pr_q[k-1], dq_q[k-1], b_q[k-1]);
        b_q[k]  <= b_q[k-1];
        bz_q[k] <= bz_q[k-1];
`ifndef DIV_PIPE_UNSIGNED_EN
        sa_q[k] <= sa_q[k-1];
        sb_q[k] <= sb_q[k-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_pipe.sv
// Directed bench for div_pipe with M=8, N=4.
// The checks cover the reset state, single-sample latency and results, sign
// combinations, edge cases, a back-to-back stream against a behavioural
// model, and reset with samples in flight.
module tb_div_pipe;
  localparam int M = 8;
  localparam int N = 4;
  localparam int LAT = M + 2;
  localparam int NSTREAM = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_in_valid = 1'b0;
  logic [M-1:0] div_in_a = '0;
  logic [N-1:0] div_in_b = '0;
  logic         div_out_valid;
  logic [M-1:0] div_out_quot;
  logic [N-1:0] div_out_rem;
  logic         div_out_zero;

  int n_assert = 0;
  int n_fail   = 0;

  div_pipe #(.M(M), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .div_in_valid  (div_in_valid),
    .div_in_a      (div_in_a),
    .div_in_b      (div_in_b),
    .div_out_valid (div_out_valid),
    .div_out_quot  (div_out_quot),
    .div_out_rem   (div_out_rem),
    .div_out_zero  (div_out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference built on the language's own division operators.
  function automatic void model(input logic [M-1:0] a, input logic [N-1:0] b,
                                output logic [M-1:0] q, output logic [N-1:0] r,
                                output logic z);
    int ia, ib, iq, ir;
`ifdef DIV_PIPE_UNSIGNED_EN
    ia = int'(a);
    ib = int'(b);
`else
    ia = int'($signed(a));
    ib = int'($signed(b));
`endif
    if (ib == 0) begin
      q = '1;
      r = '0;
      z = 1'b1;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      q  = iq[M-1:0];
      r  = ir[N-1:0];
      z  = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one sample, measure its latency, check the result and check that
  // the outputs hold afterwards.
  task automatic run_one(input string tag, input logic [M-1:0] a, input logic [N-1:0] b,
                         input logic [M-1:0] eq, input logic [N-1:0] er, input logic ez);
    int lat;
    div_in_valid = 1'b1;
    div_in_a = a;
    div_in_b = b;
    tick();
    div_in_valid = 1'b0;
    lat = 1;
    while (!div_out_valid && lat < 3 * LAT) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"},  lat, LAT);
    chk({tag, "_quot"}, div_out_quot, eq);
    chk({tag, "_rem"},  div_out_rem, er);
    chk({tag, "_zero"}, div_out_zero, ez);
    tick();
    chk({tag, "_pulse"}, div_out_valid, 1'b0);
    chk({tag, "_hold"},  div_out_quot, eq);
  endtask

  logic [M-1:0] sa [NSTREAM];
  logic [N-1:0] sb [NSTREAM];
  logic [M-1:0] mq;
  logic [N-1:0] mr;
  logic         mz;

  initial begin
    // Reset state.
    repeat (3) tick();
    chk("rst_valid", div_out_valid, 1'b0);
    chk("rst_quot",  div_out_quot, '0);
    chk("rst_rem",   div_out_rem, '0);
    chk("rst_zero",  div_out_zero, 1'b0);
    rst = 1'b0;
    tick();

`ifdef DIV_PIPE_UNSIGNED_EN
    run_one("u200_13", 8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    run_one("u255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    run_one("u9_0",    8'd9,   4'd0,  8'hFF, 4'd0, 1'b1);
`else
    // Basic result and the four sign combinations.
    run_one("p100_p7", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0);  //  100 /  7 =  14 r  2
    run_one("n100_p7", 8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0);  // -100 /  7 = -14 r -2
    run_one("p100_n7", 8'h64, 4'h9, 8'hF2, 4'h2, 1'b0);  //  100 / -7 = -14 r  2
    run_one("n100_n7", 8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0);  // -100 / -7 =  14 r -2
    // Edge cases: overflow, most negative divisor, divide by zero.
    run_one("n128_n1", 8'h80, 4'hF, 8'h80, 4'h0, 1'b0);
    run_one("n128_n8", 8'h80, 4'h8, 8'h10, 4'h0, 1'b0);
    run_one("p5_zero", 8'h05, 4'h0, 8'hFF, 4'h0, 1'b1);
    run_one("p127_n8", 8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0);  // 127 / -8 = -15 r 7
`endif

    // Back-to-back stream: one input per cycle, results compared in order.
    // The first few vectors include the zero-divisor and extreme cases.
    for (int i = 0; i < NSTREAM; i++) begin
      sa[i] = M'($urandom);
      sb[i] = N'($urandom);
    end
    sb[1] = '0;
    sa[2] = 8'h80; sb[2] = 4'hF;
    sa[3] = 8'h7F; sb[3] = 4'h8;
    for (int i = 0; i < NSTREAM + LAT; i++) begin
      if (i >= LAT) begin
        model(sa[i-LAT], sb[i-LAT], mq, mr, mz);
        chk($sformatf("strm%0d_valid", i - LAT), div_out_valid, 1'b1);
        chk($sformatf("strm%0d_quot", i - LAT), div_out_quot, mq);
        chk($sformatf("strm%0d_rem", i - LAT), div_out_rem, mr);
        chk($sformatf("strm%0d_zero", i - LAT), div_out_zero, mz);
      end
      if (i < NSTREAM) begin
        div_in_valid = 1'b1;
        div_in_a = sa[i];
        div_in_b = sb[i];
      end else begin
        div_in_valid = 1'b0;
      end
      tick();
    end
    div_in_valid = 1'b0;
    tick();
    chk("strm_end_valid", div_out_valid, 1'b0);

    // Reset with five samples in flight: none may emerge afterwards.
    for (int i = 0; i < 5; i++) begin
      div_in_valid = 1'b1;
      div_in_a = 8'h30 + 8'(i);
      div_in_b = 4'h3;
      tick();
    end
    div_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_quot", div_out_quot, '0);
    chk("midrst_rem",  div_out_rem, '0);
    chk("midrst_zero", div_out_zero, 1'b0);
    begin
      int seen = 0;
      for (int c = 0; c < 2 * LAT; c++) begin
        if (div_out_valid) seen++;
        tick();
      end
      chk("midrst_none", seen, 0);
    end
    run_one("post_rst", 8'd50, 4'd5, 8'd10, 4'd0, 1'b0);

    // rst and valid in the same cycle: the sample must be dropped.
    rst = 1'b1;
    div_in_valid = 1'b1;
    div_in_a = 8'd20;
    div_in_b = 4'd3;
    tick();
    rst = 1'b0;
    div_in_valid = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 2 * LAT; c++) begin
        if (div_out_valid) seen++;
        tick();
      end
      chk("rst_and_vld_drop", seen, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
